// File: rtl/sync_multi_filt_if.sv
// -----------------------------------------------------------------------------
// sync_multi_filt_if
// Bundle of the sample enable, the asynchronous inputs and the synchronised
// outputs of sync_multi_filt. Clock and reset stay plain ports on the module.
//   sync_clk_en  sample enable (master -> slave)
//   data_in      WIDTH asynchronous inputs (master -> slave)
//   data_out     WIDTH synchronised / filtered levels (slave -> master)
//   rise_pulse   WIDTH one-cycle 0->1 pulses on data_out (slave -> master)
//   fall_pulse   WIDTH one-cycle 1->0 pulses on data_out (slave -> master)
// -----------------------------------------------------------------------------
interface sync_multi_filt_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sync_clk_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output sync_clk_en,
    output data_in,
    input  data_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  sync_clk_en,
    input  data_in,
    output data_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface : sync_multi_filt_if

// File: rtl/sync_multi_filt.sv
// -----------------------------------------------------------------------------
// sync_multi_filt
// WIDTH independent asynchronous inputs brought into the sync_clk domain
// through a STAGES-deep flop chain, followed by an optional per-channel glitch
// filter and registered rise/fall edge pulses.
//
// Build option: define SYNC_FILTER_EN to instantiate the per-channel filter
// counters (a new level must be seen on FILT_CNT consecutive enabled samples).
// Without it, data_out simply re-registers the chain output and FILT_CNT is
// not used.
//
// Ports
//   sync_clk    destination clock
//   sync_rst_n  asynchronous active-low reset
//   bus         sync_multi_filt_if.slave: sync_clk_en, data_in, data_out,
//               rise_pulse, fall_pulse
// -----------------------------------------------------------------------------
module sync_multi_filt #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      STAGES   = 2,
  parameter int unsigned      FILT_CNT = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input logic               sync_clk,
  input logic               sync_rst_n,
  sync_multi_filt_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_multi_filt: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_multi_filt: STAGES must be >= 2");
  end
  if (FILT_CNT < 1) begin : g_bad_filt_cnt
    $error("sync_multi_filt: FILT_CNT must be >= 1");
  end

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] w_sync_out;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // ---------------------------------------------------------------------------
  // Synchroniser chain, advances only on enabled cycles.
  // NOTE: the chain is a flop array, not a RAM, so every entry is reset; a
  // real memory would be left unreset. State is always written with <= so
  // all flops sample the pre-edge values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      for (int k = 0; k < STAGES; k++) r_sync[k] <= RST_VAL;
    end else if (bus.sync_clk_en) begin
      r_sync[0] <= bus.data_in;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync_out = r_sync[STAGES-1];

`ifdef SYNC_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILT_CNT + 1);

  logic [CNT_W-1:0] r_cnt     [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

  // Per-channel qualification: a differing level is accepted on the
  // FILT_CNT-th consecutive enabled sample; any agreeing sample restarts it.
  // With the enable low everything holds, so counting resumes afterwards.
  // NOTE: defaults first so every path assigns every output (no latches).
  always_comb begin
    w_data_nxt = r_data_out;
    for (int i = 0; i < WIDTH; i++) w_cnt_nxt[i] = r_cnt[i];
    if (bus.sync_clk_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync_out[i] == r_data_out[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_W'(FILT_CNT - 1)) begin
          w_data_nxt[i] = w_sync_out[i];
          w_cnt_nxt[i]  = '0;
        end else begin
          w_cnt_nxt[i]  = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  // Unfiltered: one extra register stage after the chain.
  always_comb begin
    w_data_nxt = bus.sync_clk_en ? w_sync_out : r_data_out;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output level and edge pulses. The pulses are derived from the next value,
  // so they become visible in the same cycle as the new data_out. They update
  // every clock (not gated by the enable), hence last exactly one cycle; with
  // the enable low w_data_nxt equals r_data_out, which clears them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_data_out <= RST_VAL;
      r_rise     <= '0;
      r_fall     <= '0;
    end else begin
      r_data_out <= w_data_nxt;
      r_rise     <= w_data_nxt & ~r_data_out;
      r_fall     <= ~w_data_nxt & r_data_out;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;

endmodule : sync_multi_filt

// File: tb/tb_sync_multi_filt.sv
// -----------------------------------------------------------------------------
// tb_sync_multi_filt
// Directed bench for sync_multi_filt (WIDTH=8, STAGES=2, FILT_CNT=3). Expected
// values are hand-derived; the latency and glitch expectations switch on
// SYNC_FILTER_EN so the bench matches whichever build it is compiled with.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sync_multi_filt;

  localparam int STAGES   = 2;
  localparam int FILT_CNT = 3;
`ifdef SYNC_FILTER_EN
  localparam int LAT = STAGES + FILT_CNT;  // edges from data_in change to data_out
  localparam bit FILT = 1'b1;
`else
  localparam int LAT = STAGES + 1;
  localparam bit FILT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  sync_multi_filt_if #(.WIDTH(8)) bus ();

  sync_multi_filt #(
    .WIDTH   (8),
    .STAGES  (STAGES),
    .FILT_CNT(FILT_CNT),
    .RST_VAL (8'h00)
  ) dut (
    .sync_clk  (clk),
    .sync_rst_n(rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_do,
                           input logic [7:0] e_rise, input logic [7:0] e_fall);
    check({tag, ".data_out"}, bus.data_out, e_do);
    check({tag, ".rise"}, bus.rise_pulse, e_rise);
    check({tag, ".fall"}, bus.fall_pulse, e_fall);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [7:0] v);
    bus.data_in = v;
    step(LAT + 2);
    check_all("settle", v, 8'h00, 8'h00);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Reset with all inputs high: outputs stay at reset level, no pulses.
    rst_n           = 1'b0;
    bus.sync_clk_en = 1'b1;
    bus.data_in     = 8'hFF;
    #1;
    check_all("rst_t0", 8'h00, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step(1);
      check_all("rst_hold", 8'h00, 8'h00, 8'h00);
    end

    // Release with data_in held: no pulse at release, rise 8'hFF after LAT.
    rst_n = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      step(1);
      check_all("rst_rel", (c >= LAT) ? 8'hFF : 8'h00,
                (c == LAT) ? 8'hFF : 8'h00, 8'h00);
    end

    // Latency: data_in[0] 0->1.
    settle(8'h00);
    bus.data_in = 8'h01;
    for (int c = 1; c <= LAT + 1; c++) begin
      step(1);
      check_all("lat", (c >= LAT) ? 8'h01 : 8'h00,
                (c == LAT) ? 8'h01 : 8'h00, 8'h00);
    end

    // Glitch: data_in[3] high for two sampled edges, then low.
    settle(8'h00);
    bus.data_in = 8'h08;
    for (int c = 1; c <= STAGES + 4; c++) begin
      if (c == 3) bus.data_in = 8'h00;
      step(1);
      if (FILT) begin
        check_all("glitch", 8'h00, 8'h00, 8'h00);
      end else begin
        check_all("glitch",
                  (c == STAGES + 1 || c == STAGES + 2) ? 8'h08 : 8'h00,
                  (c == STAGES + 1) ? 8'h08 : 8'h00,
                  (c == STAGES + 3) ? 8'h08 : 8'h00);
      end
    end

    // Enable gating: data_in[5] 1->0 with the enable toggling 1,0,1,0...
    settle(8'h20);
    bus.data_in = 8'h00;
    for (int c = 1; c <= 2 * LAT + 1; c++) begin
      bus.sync_clk_en = (c % 2 == 1);
      step(1);
      check_all("en_gate", (c >= 2 * LAT - 1) ? 8'h00 : 8'h20, 8'h00,
                (c == 2 * LAT - 1) ? 8'h20 : 8'h00);
    end
    bus.sync_clk_en = 1'b1;

    // Multi-channel: simultaneous rises and falls.
    settle(8'h0F);
    bus.data_in = 8'hF0;
    step(LAT - 1);
    check_all("multi_pre", 8'h0F, 8'h00, 8'h00);
    step(1);
    check_all("multi_edge", 8'hF0, 8'hF0, 8'h0F);
    step(1);
    check_all("multi_post", 8'hF0, 8'h00, 8'h00);

    // Reset while channel 1 is mid-qualification.
    bus.data_in = 8'hF2;
    step(LAT - 1);
    check_all("midrst_pre", 8'hF0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst_async", 8'h00, 8'h00, 8'h00);
    step(2);
    check_all("midrst_hold", 8'h00, 8'h00, 8'h00);
    bus.data_in = 8'h00;
    rst_n       = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      step(1);
      check_all("midrst_rel", 8'h00, 8'h00, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sync_multi_filt
